// File: rtl/riscv_pkg.sv
// Shared core package: machine width, opcodes and the fetch bundle.
// Imported by every pipeline stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode.
// Head is held in a register so it stays put once the buffer drains.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] rem;
  logic [CW-1:0] cnt_nxt;
  logic          do_pop;
  fetch_entry_t  head_nxt;

  always_comb begin
    do_pop   = pop && (count != '0);
    rd_nxt   = rd + AW'(do_pop);
    rem      = count - CW'(do_pop);
    cnt_nxt  = rem + CW'(push);
    // an entry written into an empty buffer becomes the head directly
    head_nxt = (rem == '0) ? wdata : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      head  <= '{instr: NOP_INSTR, pc: '0};
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr <= wr + AW'(1);
      end
      rd    <= rd_nxt;
      count <= cnt_nxt;
      if (cnt_nxt != '0) begin
        head <= head_nxt;
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !flush && (count == CW'(DEPTH)))
  );

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, issues credit-limited imem reads and
// streams returned words to decode, dropping fetches killed by redirects.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tags [FIFO_DEPTH];
  logic [AW-1:0]   twr;
  logic [AW-1:0]   trd;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   outst_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fcount;
  logic [UW-1:0]   used;
  logic            req_fire;
  logic            pop;
  logic            keep;
  fetch_entry_t    head;
  fetch_entry_t    wentry;

  assign instr_valid   = (fcount != '0);
  assign instr         = head.instr;
  assign instr_pc      = head.pc;
  assign imem_req_addr = pc;
  assign pop           = instr_valid && instr_ready;

  always_comb begin
    // a slot freed by this cycle's pop is reusable: no response
    // to a new request can land before the next cycle
    used = UW'(fcount) + UW'(outst) - UW'(pop);
    imem_req_valid = rst_n && (used < UW'(FIFO_DEPTH));
    req_fire  = imem_req_valid && imem_req_ready;
    keep      = imem_rsp_valid && (discard == '0) && !redirect_valid;
    outst_nxt = outst + CW'(req_fire) - CW'(imem_rsp_valid);
    wentry    = '{instr: imem_rsp_data, pc: tags[trd]};
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tags[twr] <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      twr     <= '0;
      trd     <= '0;
      outst   <= '0;
      discard <= '0;
    end else begin
      if (req_fire) begin
        twr <= twr + AW'(1);
      end
      if (imem_rsp_valid) begin
        trd <= trd + AW'(1);
      end
      outst <= outst_nxt;
      if (redirect_valid) begin
        pc      <= {redirect_pc[XLEN-1:2], 2'b00};
        discard <= outst_nxt;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (imem_rsp_valid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (keep),
    .wdata (wentry),
    .pop   (pop),
    .head  (head),
    .count (fcount)
  );

  a_rsp_expected: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst != '0)
  );

  a_credit_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    (UW'(fcount) + UW'(outst)) <= UW'(FIFO_DEPTH)
  );

  a_discard_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    discard <= outst
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a queue-based fetch model,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        imem_req_valid;
  logic        imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        instr_valid;
  logic        instr_ready = 0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;

  logic        rv2;
  logic [31:0] addr2;
  logic        iv2;
  logic [31:0] instr2;
  logic [31:0] ipc2;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(rv2), .imem_req_ready(imem_req_ready),
    .imem_req_addr(addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(iv2), .instr_ready(instr_ready),
    .instr(instr2), .instr_pc(ipc2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  req_t        memq[$];
  ent_t        q[$];
  ent_t        last;
  logic [31:0] pc_m;
  logic [31:0] acc_q[$];
  logic [31:0] deliv_pcs[$];
  logic [31:0] a2[3];
  int          deliv;
  int          cyc;
  int          tests = 0;
  int          fails = 0;

  int          rdy_pct = 100;
  int          irdy_pct = 100;
  int          redir_pm = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_redir = 0;
  logic [31:0] force_pc = 0;

  logic        last_rv;
  logic [31:0] last_addr;
  logic [31:0] last_instr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    q.delete();
    last = '{instr: NOP, pc: 32'h0};
    pc_m = 32'h0;
    cyc = 0;
    force_redir = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    instr_ready = 0;
    redirect_valid = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic step();
    bit   pop, exp_rv, acc;
    req_t r;
    ent_t e;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready    = ($urandom_range(99) < irdy_pct);
    redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
    redirect_pc    = force_redir ? force_pc : $urandom;
    force_redir    = 0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = $urandom;
    end
    #1;
    pop    = (q.size() != 0) && instr_ready;
    exp_rv = (q.size() + memq.size() - int'(pop)) < DEPTH;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, pc_m);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr", instr, q[0].instr);
      chk("instr_pc", instr_pc, q[0].pc);
      last = q[0];
    end else begin
      chk("instr_hold", instr, last.instr);
      chk("instr_pc_hold", instr_pc, last.pc);
    end
    last_rv    = imem_req_valid;
    last_addr  = imem_req_addr;
    last_instr = instr;
    if (cyc < 3) a2[cyc] = addr2;
    if (pop) begin
      e = q.pop_front();
      deliv++;
      deliv_pcs.push_back(e.pc);
    end
    if (imem_rsp_valid) begin
      r = memq.pop_front();
      if (!r.stale && !redirect_valid)
        q.push_back('{instr: r.data, pc: r.addr});
    end
    acc = exp_rv && imem_req_ready;
    if (acc) begin
      r.addr  = pc_m;
      r.data  = $urandom;
      r.due   = cyc + int'($urandom_range(lat_max, lat_min));
      r.stale = redirect_valid;
      memq.push_back(r);
      acc_q.push_back(pc_m);
      pc_m = pc_m + 32'd4;
    end
    if (redirect_valid) begin
      foreach (memq[i]) memq[i].stale = 1;
      q.delete();
      pc_m = redirect_pc & ~32'd3;
    end
    cyc++;
  endtask

  task automatic knobs(int rp, int ip, int rd, int lmin, int lmax);
    rdy_pct = rp;
    irdy_pct = ip;
    redir_pm = rd;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    deliv_pcs.delete();
    deliv = 0;
  endtask

  initial begin
    int d0;
    model_reset();

    // streaming from reset, 1-cycle memory
    do_reset();
    knobs(100, 100, 0, 1, 1);
    clear_logs();
    repeat (5) step();
    d0 = deliv;
    repeat (15) step();
    chk("t1_acc0", acc_q[0], 32'h0);
    chk("t1_acc1", acc_q[1], 32'h4);
    chk("t1_acc2", acc_q[2], 32'h8);
    chk("t1_sustained", 32'(deliv - d0), 32'd15);
    chk("t5_addr0", a2[0], 32'hFFFF_FFF8);
    chk("t5_addr1", a2[1], 32'hFFFF_FFFC);
    chk("t5_addr2", a2[2], 32'h0000_0000);

    // decode stalled: only DEPTH requests go out
    do_reset();
    knobs(100, 0, 0, 1, 1);
    clear_logs();
    repeat (10) step();
    chk("t2_acc_count", 32'(acc_q.size()), 32'(DEPTH));
    chk("t2_req_off", 32'(last_rv), 32'h0);
    knobs(100, 100, 0, 1, 1);
    repeat (10) step();
    chk("t2_first_pc", deliv_pcs[0], 32'h0);
    chk("t2_second_pc", deliv_pcs[1], 32'h4);

    // memory stalls with a request pending at 8
    do_reset();
    knobs(100, 100, 0, 1, 1);
    clear_logs();
    repeat (2) step();
    knobs(0, 100, 0, 1, 1);
    repeat (5) step();
    chk("t3_req_valid", 32'(last_rv), 32'h1);
    chk("t3_addr", last_addr, 32'h8);
    knobs(100, 100, 0, 1, 1);
    repeat (10) step();
    chk("t3_resume", acc_q[2], 32'h8);

    // redirect with two fetches in flight
    do_reset();
    knobs(100, 100, 0, 3, 3);
    clear_logs();
    repeat (2) step();
    acc_q.delete();
    deliv_pcs.delete();
    force_redir = 1;
    force_pc = 32'h0000_0103;
    step();
    repeat (10) step();
    chk("t4_new_addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h100);
    chk("t4_first_pc", deliv_pcs.size() > 0 ? deliv_pcs[0] : 32'hDEAD_BEEF, 32'h100);

    // random traffic with redirects, then reset mid-stream
    knobs(70, 60, 40, 1, 4);
    repeat (600) step();
    do_reset();
    knobs(100, 100, 0, 1, 1);
    step();
    chk("t6_restart_addr", last_addr, 32'h0);
    chk("t6_restart_instr", last_instr, NOP);
    knobs(70, 60, 40, 1, 4);
    repeat (400) step();
    knobs(50, 90, 10, 1, 2);
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
